// File: rtl/s_pkg.sv
// Shared types and helpers for the slot allocator and its first-zero finder.
package s_pkg;

  typedef enum logic {
    POLICY_RR,
    POLICY_LOWEST
  } policy_t;

  // Width of a slot ID for a W-entry resource.
  function automatic int unsigned clog2w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/s.sv
// Circular first-zero finder: returns the first 0 in x_i searching downward
// from pos_i-1 with wrap-around, or the lowest 0 when any_i is set.
module s
  import s_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]           x_i,
  input  logic [clog2w(W)-1:0]   pos_i,
  input  logic                   any_i,
  output logic [clog2w(W)-1:0]   y_enc_o
);

  localparam int unsigned IDW = clog2w(W);

  logic [IDW-1:0] idx;

  // Candidates are scanned farthest-first so the nearest zero is the last
  // assignment to stick; k = W wraps back onto pos_i itself.
  always_comb begin
    y_enc_o = '0;
    idx     = '0;
    if (any_i) begin
      for (int unsigned i = W; i > 0; i--) begin
        if (!x_i[i-1]) y_enc_o = IDW'(i - 1);
      end
    end else begin
      for (int unsigned k = W; k > 0; k--) begin
        idx = pos_i - IDW'(k);
        if (!x_i[idx]) y_enc_o = idx;
      end
    end
  end

endmodule

// File: rtl/slot_alloc.sv
// Circular slot/tag allocator: holds occupancy, search pointer and count,
// grants one free slot per cycle and accepts slot returns.
module slot_alloc
  import s_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter policy_t     POLICY = POLICY_RR
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   alloc_vld_i,
  output logic                   alloc_rdy_o,
  output logic [clog2w(W)-1:0]   alloc_id_o,
  input  logic                   free_vld_i,
  input  logic [clog2w(W)-1:0]   free_id_i,
  input  logic                   flush_i,
  output logic [W-1:0]           occ_o,
  output logic [clog2w(W):0]     cnt_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   err_o
);

  localparam int unsigned IDW = clog2w(W);
  localparam int unsigned CW  = IDW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]   occ_q, occ_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [IDW-1:0] grant_id;
  logic           full;
  logic           alloc_fire;
  logic           free_legal;
  logic           free_illegal;

  s #(
    .W(W)
  ) u_s (
    .x_i    (occ_q),
    .pos_i  (ptr_q),
    .any_i  (POLICY == POLICY_LOWEST),
    .y_enc_o(grant_id)
  );

  // Handshake and free-legality decode from registered state.
  always_comb begin
    full         = (cnt_q == CNT_FULL);
    alloc_fire   = alloc_vld_i & ~full;
    free_legal   = free_vld_i & occ_q[free_id_i];
    free_illegal = free_vld_i & ~occ_q[free_id_i];
  end

  // Next-state: flush overrides everything; otherwise alloc and free both apply.
  always_comb begin
    occ_d = occ_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (flush_i) begin
      occ_d = '0;
      ptr_d = '0;
      cnt_d = '0;
    end else begin
      err_d = free_illegal;
      if (alloc_fire) begin
        occ_d[grant_id] = 1'b1;
        if (POLICY == POLICY_RR) ptr_d = grant_id;
      end
      // A legal free targets an occupied slot, so it can never collide with
      // the slot granted in the same cycle.
      if (free_legal) occ_d[free_id_i] = 1'b0;
      unique case ({alloc_fire, free_legal})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      occ_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Outputs come only from registered state.
  always_comb begin
    alloc_rdy_o = ~full;
    alloc_id_o  = grant_id;
    occ_o       = occ_q;
    cnt_o       = cnt_q;
    full_o      = full;
    empty_o     = (cnt_q == '0);
    err_o       = err_q;
  end

  a_cnt_matches_occ : assert property (
    @(posedge clk) disable iff (!arst_n) cnt_q == CW'($countones(occ_q))
  );

endmodule

// File: tb/tb_slot_alloc.sv
// Self-checking bench for slot_alloc: one RR and one LOWEST instance share
// stimulus and are compared against a behavioural occupancy model.
module tb_slot_alloc;
  import s_pkg::*;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       alloc_vld_i = 1'b0;
  logic       free_vld_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [3:0] free_id_i = '0;

  logic        rr_rdy, lo_rdy, rr_full, lo_full, rr_empty, lo_empty, rr_err, lo_err;
  logic [3:0]  rr_id, lo_id;
  logic [15:0] rr_occ, lo_occ;
  logic [4:0]  rr_cnt, lo_cnt;
  logic [28:0] rr_obs, lo_obs;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = RR instance, 1 = LOWEST instance.
  logic [W-1:0] m_occ [2];
  int           m_ptr [2];
  logic         m_err [2];

  always #5 clk = ~clk;

  slot_alloc #(.W(W), .POLICY(POLICY_RR)) u_rr (
    .clk(clk), .arst_n(arst_n), .alloc_vld_i(alloc_vld_i), .alloc_rdy_o(rr_rdy),
    .alloc_id_o(rr_id), .free_vld_i(free_vld_i), .free_id_i(free_id_i),
    .flush_i(flush_i), .occ_o(rr_occ), .cnt_o(rr_cnt), .full_o(rr_full),
    .empty_o(rr_empty), .err_o(rr_err)
  );

  slot_alloc #(.W(W), .POLICY(POLICY_LOWEST)) u_lo (
    .clk(clk), .arst_n(arst_n), .alloc_vld_i(alloc_vld_i), .alloc_rdy_o(lo_rdy),
    .alloc_id_o(lo_id), .free_vld_i(free_vld_i), .free_id_i(free_id_i),
    .flush_i(flush_i), .occ_o(lo_occ), .cnt_o(lo_cnt), .full_o(lo_full),
    .empty_o(lo_empty), .err_o(lo_err)
  );

  // The granted ID is meaningless when no slot is free, so it is masked.
  assign rr_obs = {rr_rdy, rr_id & {4{rr_rdy}}, rr_occ, rr_cnt, rr_full, rr_empty, rr_err};
  assign lo_obs = {lo_rdy, lo_id & {4{lo_rdy}}, lo_occ, lo_cnt, lo_full, lo_empty, lo_err};

  function automatic int m_cnt(input int p);
    return $countones(m_occ[p]);
  endfunction

  // RR: nearest free slot below the last grant, wrapping; LOWEST: smallest free.
  function automatic int exp_id(input int p);
    if (p == 1) begin
      for (int i = 0; i < W; i++) if (!m_occ[p][i]) return i;
    end else begin
      for (int k = 1; k <= W; k++) begin
        int idx;
        idx = (m_ptr[p] + W - k) % W;
        if (!m_occ[p][idx]) return idx;
      end
    end
    return 0;
  endfunction

  function automatic logic [28:0] exp_bundle(input int p);
    logic rdy;
    rdy = (m_cnt(p) != W);
    return {rdy, rdy ? 4'(exp_id(p)) : 4'd0, m_occ[p], 5'(m_cnt(p)),
            m_cnt(p) == W, m_cnt(p) == 0, m_err[p]};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_occ[p] = '0;
      m_ptr[p] = 0;
      m_err[p] = 1'b0;
    end
  endtask

  // Apply one cycle of stimulus, advance past the edge, update the model.
  task automatic tick(input logic av, input logic fv, input logic [3:0] fid, input logic fl);
    logic [W-1:0] nocc [2];
    int           nptr [2];
    logic         nerr [2];
    int           id;
    alloc_vld_i = av;
    free_vld_i  = fv;
    free_id_i   = fid;
    flush_i     = fl;
    for (int p = 0; p < 2; p++) begin
      nocc[p] = m_occ[p];
      nptr[p] = m_ptr[p];
      nerr[p] = 1'b0;
      if (fl) begin
        nocc[p] = '0;
        nptr[p] = 0;
      end else begin
        id = exp_id(p);
        if (av && m_cnt(p) != W) begin
          nocc[p][id] = 1'b1;
          if (p == 0) nptr[p] = id;
        end
        if (fv) begin
          if (m_occ[p][fid]) nocc[p][fid] = 1'b0;
          else nerr[p] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      m_occ[p] = nocc[p];
      m_ptr[p] = nptr[p];
      m_err[p] = nerr[p];
    end
    alloc_vld_i = 1'b0;
    free_vld_i  = 1'b0;
    free_id_i   = '0;
    flush_i     = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (rr_obs !== 29'({1'b1, 4'd15, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0})) begin
      n_fail++; $display("FAIL reset_rr: got %h want %h", rr_obs,
                         29'({1'b1, 4'd15, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0}));
    end
    n_tests++;
    if (lo_obs !== 29'({1'b1, 4'd0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0})) begin
      n_fail++; $display("FAIL reset_lo: got %h want %h", lo_obs,
                         29'({1'b1, 4'd0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0}));
    end
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_grants();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rr_id !== 4'(15 - i)) begin
        n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", i, rr_id, 15 - i);
      end
      tick(1'b1, 1'b0, 4'd0, 1'b0);
    end
    n_tests++;
    if (rr_cnt !== 5'd3 || rr_occ !== 16'hE000) begin
      n_fail++; $display("FAIL rr_three: got cnt=%0d occ=%h want cnt=3 occ=e000", rr_cnt, rr_occ);
    end
    n_tests++;
    if (lo_obs !== exp_bundle(1)) begin
      n_fail++; $display("FAIL rr_three_lo_model: got %h want %h", lo_obs, exp_bundle(1));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_fill_free();
    repeat (16) tick(1'b1, 1'b0, 4'd0, 1'b0);
    n_tests++;
    if (rr_full !== 1'b1 || rr_rdy !== 1'b0 || rr_cnt !== 5'd16) begin
      n_fail++; $display("FAIL fill_full: got full=%b rdy=%b cnt=%0d want 1 0 16", rr_full, rr_rdy, rr_cnt);
    end
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    n_tests++;
    if (rr_cnt !== 5'd16 || rr_occ !== 16'hFFFF) begin
      n_fail++; $display("FAIL alloc_while_full: got cnt=%0d occ=%h want 16 ffff", rr_cnt, rr_occ);
    end
    // Requester keeps asking while the slot is returned; no grant that cycle.
    tick(1'b1, 1'b1, 4'd7, 1'b0);
    n_tests++;
    if (rr_rdy !== 1'b1 || rr_id !== 4'd7 || rr_cnt !== 5'd15) begin
      n_fail++; $display("FAIL free_when_full: got rdy=%b id=%0d cnt=%0d want 1 7 15", rr_rdy, rr_id, rr_cnt);
    end
    n_tests++;
    if (lo_obs !== exp_bundle(1)) begin
      n_fail++; $display("FAIL fill_lo_model: got %h want %h", lo_obs, exp_bundle(1));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_lowest();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (lo_id !== 4'(i)) begin
        n_fail++; $display("FAIL lo_grant%0d: got %0d want %0d", i, lo_id, i);
      end
      tick(1'b1, 1'b0, 4'd0, 1'b0);
    end
    n_tests++;
    if (lo_id !== 4'd3) begin
      n_fail++; $display("FAIL lo_next: got %0d want 3", lo_id);
    end
    tick(1'b0, 1'b1, 4'd1, 1'b0);
    n_tests++;
    if (lo_id !== 4'd1 || lo_cnt !== 5'd2) begin
      n_fail++; $display("FAIL lo_refill: got id=%0d cnt=%0d want 1 2", lo_id, lo_cnt);
    end
    n_tests++;
    if (rr_obs !== exp_bundle(0)) begin
      n_fail++; $display("FAIL lo_rr_model: got %h want %h", rr_obs, exp_bundle(0));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    n_tests++;
    if (rr_occ !== 16'h8000 || rr_id !== 4'd14) begin
      n_fail++; $display("FAIL simul_setup: got occ=%h id=%0d want 8000 14", rr_occ, rr_id);
    end
    tick(1'b1, 1'b1, 4'd15, 1'b0);
    n_tests++;
    if (rr_occ !== 16'h4000 || rr_cnt !== 5'd1 || rr_err !== 1'b0) begin
      n_fail++; $display("FAIL simul_rr: got occ=%h cnt=%0d err=%b want 4000 1 0", rr_occ, rr_cnt, rr_err);
    end
    n_tests++;
    if (lo_obs !== exp_bundle(1)) begin
      n_fail++; $display("FAIL simul_lo_model: got %h want %h", lo_obs, exp_bundle(1));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_illegal_free();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b1, 4'd4, 1'b0);
    n_tests++;
    if (rr_err !== 1'b1 || rr_occ !== 16'hC000 || rr_cnt !== 5'd2) begin
      n_fail++; $display("FAIL illegal_pulse: got err=%b occ=%h cnt=%0d want 1 c000 2", rr_err, rr_occ, rr_cnt);
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0);
    n_tests++;
    if (rr_err !== 1'b0 || lo_err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_one_cycle: got rr_err=%b lo_err=%b want 0 0", rr_err, lo_err);
    end
    tick(1'b1, 1'b1, 4'd4, 1'b0);
    n_tests++;
    if (rr_err !== 1'b1 || rr_cnt !== 5'd3 || rr_occ !== 16'hE000) begin
      n_fail++; $display("FAIL illegal_with_alloc: got err=%b cnt=%0d occ=%h want 1 3 e000", rr_err, rr_cnt, rr_occ);
    end
    n_tests++;
    if (lo_obs !== exp_bundle(1)) begin
      n_fail++; $display("FAIL illegal_lo_model: got %h want %h", lo_obs, exp_bundle(1));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_flush_reset();
    repeat (5) tick(1'b1, 1'b0, 4'd0, 1'b0);
    tick(1'b1, 1'b1, 4'd15, 1'b1);
    n_tests++;
    if (rr_occ !== 16'h0 || rr_cnt !== 5'd0 || rr_id !== 4'd15 || rr_err !== 1'b0) begin
      n_fail++; $display("FAIL flush_rr: got occ=%h cnt=%0d id=%0d err=%b want 0 0 15 0", rr_occ, rr_cnt, rr_id, rr_err);
    end
    n_tests++;
    if (lo_occ !== 16'h0 || lo_cnt !== 5'd0 || lo_id !== 4'd0 || lo_err !== 1'b0) begin
      n_fail++; $display("FAIL flush_lo: got occ=%h cnt=%0d id=%0d err=%b want 0 0 0 0", lo_occ, lo_cnt, lo_id, lo_err);
    end
    repeat (3) tick(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    arst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (rr_occ !== 16'h0 || rr_cnt !== 5'd0 || rr_id !== 4'd15 || rr_empty !== 1'b1 || rr_rdy !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_rr: got occ=%h cnt=%0d id=%0d empty=%b rdy=%b want 0 0 15 1 1",
                         rr_occ, rr_cnt, rr_id, rr_empty, rr_rdy);
    end
    n_tests++;
    if (lo_occ !== 16'h0 || lo_cnt !== 5'd0 || lo_id !== 4'd0) begin
      n_fail++; $display("FAIL async_reset_lo: got occ=%h cnt=%0d id=%0d want 0 0 0", lo_occ, lo_cnt, lo_id);
    end
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, W - 1)), $urandom_range(0, 63) == 0);
      n_tests++;
      if (rr_obs !== exp_bundle(0)) begin
        n_fail++; $display("FAIL rand_rr cycle %0d: got %h want %h", i, rr_obs, exp_bundle(0));
      end
      n_tests++;
      if (lo_obs !== exp_bundle(1)) begin
        n_fail++; $display("FAIL rand_lo cycle %0d: got %h want %h", i, lo_obs, exp_bundle(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_grants();
    test_fill_free();
    test_lowest();
    test_simultaneous();
    test_illegal_free();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
